// File: rtl/fml_arbiter.sv
`default_nettype none
// ============================================================================
// fml_arbiter: N-port FML burst arbiter (round-robin or fixed priority) in
// front of a single FML slave; steers write bursts, broadcasts read data.
// Rev 1.0
// ============================================================================
module fml_arbiter #(
    parameter int NPORTS = 4,
    parameter int ADR_W  = 26,
    parameter int DW     = 32,
    parameter int BL     = 4,
    parameter int RR     = 1
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst_n,
    input  logic [NPORTS*ADR_W-1:0]   m_adr,
    input  logic [NPORTS-1:0]         m_stb,
    input  logic [NPORTS-1:0]         m_we,
    input  logic [NPORTS*DW/8-1:0]    m_sel,
    input  logic [NPORTS*DW-1:0]      m_di,
    output logic [NPORTS-1:0]         m_eack,
    output logic [DW-1:0]             m_do,
    output logic [ADR_W-1:0]          s_adr,
    output logic                      s_stb,
    output logic                      s_we,
    output logic [DW/8-1:0]           s_sel,
    output logic [DW-1:0]             s_di,
    input  logic                      s_eack,
    input  logic [DW-1:0]             s_do,
    output logic                      busy
);
    localparam int GW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
    localparam int CW = $clog2(BL + 1);
    localparam int SW = DW / 8;
    localparam logic [GW-1:0] LAST_RST = GW'(NPORTS - 1);
    localparam logic [CW-1:0] BL_CNT   = CW'(BL);

    typedef enum logic [0:0] {
        S_IDLE    = 1'b0,
        S_GRANTED = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [GW-1:0]   last_q,  last_d;
    logic [GW-1:0]   wsel_q,  wsel_d;
    logic [CW-1:0]   wcnt_q,  wcnt_d;
    logic [GW-1:0]   winner;
    logic [GW-1:0]   cand;

    logic [ADR_W-1:0] adr_a [NPORTS];
    logic [DW-1:0]    di_a  [NPORTS];
    logic [SW-1:0]    sel_a [NPORTS];

    for (genvar i = 0; i < NPORTS; i++) begin : g_unpack
        assign adr_a[i] = m_adr[i*ADR_W +: ADR_W];
        assign di_a[i]  = m_di[i*DW +: DW];
        assign sel_a[i] = m_sel[i*SW +: SW];
    end

    // Scan candidates from lowest to highest search rank; the last hit is
    // overwritten by any better-ranked one, leaving the first in order.
    always_comb begin
        winner = '0;
        cand   = '0;
        for (int k = NPORTS - 1; k >= 0; k--) begin
            cand = (RR != 0) ? GW'((int'(last_q) + 1 + k) % NPORTS) : GW'(k);
            if (m_stb[cand]) begin
                winner = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        wsel_d  = wsel_q;
        wcnt_d  = (wcnt_q != '0) ? wcnt_q - 1'b1 : wcnt_q;
        s_stb   = 1'b0;
        m_eack  = '0;
        case (state_q)
            S_IDLE: begin
                if (|m_stb) begin
                    grant_d = winner;
                    state_d = S_GRANTED;
                end
            end
            S_GRANTED: begin
                s_stb = m_stb[grant_q];
                if (!m_stb[grant_q]) begin
                    state_d = S_IDLE;
                end else if (s_eack) begin
                    m_eack[grant_q] = 1'b1;
                    last_d          = grant_q;
                    state_d         = S_IDLE;
                    if (m_we[grant_q]) begin
                        wsel_d = grant_q;
                        wcnt_d = BL_CNT;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Write data follows wsel only, so a new grant cannot disturb a burst.
    assign s_adr = adr_a[grant_q];
    assign s_we  = m_we[grant_q];
    assign s_di  = (wcnt_q != '0) ? di_a[wsel_q]  : '0;
    assign s_sel = (wcnt_q != '0) ? sel_a[wsel_q] : '0;
    assign m_do  = s_do;
    assign busy  = (state_q == S_GRANTED) | (wcnt_q != '0);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            last_q  <= LAST_RST;
            wsel_q  <= '0;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            wsel_q  <= wsel_d;
            wcnt_q  <= wcnt_d;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_fml_arbiter.sv
`default_nettype none
// tb_fml_arbiter: directed stimulus on a round-robin and a fixed-priority
// instance, checked every cycle against a cycle-level reference model.
module tb_fml_arbiter;
    localparam int NP = 4;
    localparam int AW = 26;
    localparam int DW = 32;
    localparam int BL = 4;
    localparam int SW = DW / 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NP*AW-1:0] m_adr  [2];
    logic [NP-1:0]    m_stb  [2];
    logic [NP-1:0]    m_we   [2];
    logic [NP*SW-1:0] m_sel  [2];
    logic [NP*DW-1:0] m_di   [2];
    logic [NP-1:0]    m_eack [2];
    logic [DW-1:0]    m_do   [2];
    logic [AW-1:0]    s_adr  [2];
    logic             s_stb  [2];
    logic             s_we   [2];
    logic [SW-1:0]    s_sel  [2];
    logic [DW-1:0]    s_di   [2];
    logic             s_eack [2];
    logic [DW-1:0]    s_do   [2];
    logic             busy   [2];

    fml_arbiter #(.NPORTS(NP), .ADR_W(AW), .DW(DW), .BL(BL), .RR(1)) u_rr (
        .sys_clk(clk), .sys_rst_n(rst_n),
        .m_adr(m_adr[0]), .m_stb(m_stb[0]), .m_we(m_we[0]), .m_sel(m_sel[0]),
        .m_di(m_di[0]), .m_eack(m_eack[0]), .m_do(m_do[0]),
        .s_adr(s_adr[0]), .s_stb(s_stb[0]), .s_we(s_we[0]), .s_sel(s_sel[0]),
        .s_di(s_di[0]), .s_eack(s_eack[0]), .s_do(s_do[0]), .busy(busy[0])
    );

    fml_arbiter #(.NPORTS(NP), .ADR_W(AW), .DW(DW), .BL(BL), .RR(0)) u_fp (
        .sys_clk(clk), .sys_rst_n(rst_n),
        .m_adr(m_adr[1]), .m_stb(m_stb[1]), .m_we(m_we[1]), .m_sel(m_sel[1]),
        .m_di(m_di[1]), .m_eack(m_eack[1]), .m_do(m_do[1]),
        .s_adr(s_adr[1]), .s_stb(s_stb[1]), .s_we(s_we[1]), .s_sel(s_sel[1]),
        .s_di(s_di[1]), .s_eack(s_eack[1]), .s_do(s_do[1]), .busy(busy[1])
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // master / slave agent state
    bit            req     [2][NP];
    bit            cont    [2][NP];
    int            rearm   [2][NP];
    int            bl_left [2][NP];
    logic [AW-1:0] radr    [2][NP];
    bit            rwe     [2][NP];
    logic [DW-1:0] dbase   [2][NP];
    logic [DW-1:0] di_nx   [2][NP];
    logic [SW-1:0] sel_nx  [2][NP];
    int            ack_dly [2];
    int            age     [2];
    bit            ack_nx  [2];

    // reference model state: current owner (-1 none), last served, last write eack
    int own  [2];
    int lastp[2];
    int wr_e [2];
    int wr_p [2];

    logic [NP-1:0] sn_eack [2];
    logic          sn_stb  [2];
    logic          sn_busy [2];
    logic [AW-1:0] sn_adr  [2];
    logic [DW-1:0] sn_di   [2];
    logic [DW-1:0] sn_do   [2];
    logic [DW-1:0] sn_sdo  [2];
    logic [SW-1:0] sn_sel  [2];

    int got[8];
    int ngot;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(string nm);
        checks++;
        failures++;
        $display("FAIL %s actual=no_eack required=eack_within_bound t=%0t", nm, $time);
    endtask

    function automatic int pick(int u);
        int r = -1;
        if (u == 0) begin
            for (int k = 1; k <= NP; k++)
                if (r < 0 && m_stb[u][(lastp[u] + k) % NP]) r = (lastp[u] + k) % NP;
        end else begin
            for (int p = 0; p < NP; p++)
                if (r < 0 && m_stb[u][p]) r = p;
        end
        return r;
    endfunction

    function automatic int eack_port(logic [NP-1:0] v);
        int r = -1;
        for (int p = NP - 1; p >= 0; p--)
            if (v[p]) r = p;
        return r;
    endfunction

    task automatic model_check();
        logic          es;
        logic [NP-1:0] ee;
        logic          inb;
        logic [DW-1:0] edi;
        logic [SW-1:0] esel;
        string         tag;
        for (int u = 0; u < 2; u++) begin
            tag = (u == 0) ? "rr" : "fp";
            if (!rst_n) begin
                chk({tag, ".rst_s_stb"}, 64'(s_stb[u]), 64'd0);
                chk({tag, ".rst_m_eack"}, 64'(m_eack[u]), 64'd0);
                chk({tag, ".rst_s_sel"}, 64'(s_sel[u]), 64'd0);
                chk({tag, ".rst_s_di"}, 64'(s_di[u]), 64'd0);
                chk({tag, ".rst_busy"}, 64'(busy[u]), 64'd0);
                own[u]   = -1;
                lastp[u] = NP - 1;
                wr_e[u]  = -1000;
            end else begin
                es = (own[u] >= 0) && m_stb[u][own[u]];
                ee = '0;
                if (es && s_eack[u]) ee[own[u]] = 1'b1;
                inb  = (cyc > wr_e[u]) && (cyc <= wr_e[u] + BL);
                edi  = inb ? m_di[u][wr_p[u]*DW +: DW] : '0;
                esel = inb ? m_sel[u][wr_p[u]*SW +: SW] : '0;
                chk({tag, ".s_stb"}, 64'(s_stb[u]), 64'(es));
                if (es) begin
                    chk({tag, ".s_adr"}, 64'(s_adr[u]), 64'(m_adr[u][own[u]*AW +: AW]));
                    chk({tag, ".s_we"}, 64'(s_we[u]), 64'(m_we[u][own[u]]));
                end
                chk({tag, ".m_eack"}, 64'(m_eack[u]), 64'(ee));
                chk({tag, ".s_di"}, 64'(s_di[u]), 64'(edi));
                chk({tag, ".s_sel"}, 64'(s_sel[u]), 64'(esel));
                chk({tag, ".busy"}, 64'(busy[u]), 64'((own[u] >= 0) || inb));
                chk({tag, ".m_do"}, 64'(m_do[u]), 64'(s_do[u]));
                if (es && s_eack[u] && m_we[u][own[u]]) begin
                    wr_e[u] = cyc;
                    wr_p[u] = own[u];
                end
                if (own[u] >= 0) begin
                    if (!m_stb[u][own[u]]) begin
                        own[u] = -1;
                    end else if (s_eack[u]) begin
                        lastp[u] = own[u];
                        own[u]   = -1;
                    end
                end else if (|m_stb[u]) begin
                    own[u] = pick(u);
                end
            end
        end
    endtask

    task automatic observe();
        for (int u = 0; u < 2; u++) begin
            if (rst_n) begin
                for (int p = 0; p < NP; p++) begin
                    if (rearm[u][p] > 0) begin
                        rearm[u][p]--;
                        if (rearm[u][p] == 0) req[u][p] = 1'b1;
                    end
                    if (m_eack[u][p]) begin
                        req[u][p] = 1'b0;
                        if (cont[u][p]) rearm[u][p] = 1;
                        if (m_we[u][p]) bl_left[u][p] = BL;
                    end
                    if (bl_left[u][p] > 0) begin
                        di_nx[u][p]  = dbase[u][p] + DW'(BL - bl_left[u][p]);
                        sel_nx[u][p] = '1;
                        bl_left[u][p]--;
                    end else begin
                        di_nx[u][p]  = DW'(32'hDEAD_0000 + p);
                        sel_nx[u][p] = SW'(5);
                    end
                end
                if (s_stb[u] && !s_eack[u]) age[u]++;
                else age[u] = 0;
                ack_nx[u] = (age[u] == ack_dly[u]);
            end
        end
    endtask

    task automatic apply();
        for (int u = 0; u < 2; u++) begin
            for (int p = 0; p < NP; p++) begin
                m_stb[u][p]            = req[u][p];
                m_we[u][p]             = rwe[u][p];
                m_adr[u][p*AW +: AW]   = radr[u][p];
                m_di[u][p*DW +: DW]    = di_nx[u][p];
                m_sel[u][p*SW +: SW]   = sel_nx[u][p];
            end
            s_eack[u] = ack_nx[u];
            s_do[u]   = DW'($urandom());
        end
    endtask

    task automatic agents_clear();
        for (int u = 0; u < 2; u++) begin
            for (int p = 0; p < NP; p++) begin
                req[u][p] = 1'b0; cont[u][p] = 1'b0; rearm[u][p] = 0; bl_left[u][p] = 0;
                rwe[u][p] = 1'b0; radr[u][p] = '0; dbase[u][p] = '0;
                di_nx[u][p] = DW'(32'hDEAD_0000 + p); sel_nx[u][p] = SW'(5);
            end
            age[u] = 0; ack_nx[u] = 1'b0;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            sn_eack[u] = m_eack[u]; sn_stb[u] = s_stb[u]; sn_busy[u] = busy[u];
            sn_adr[u] = s_adr[u]; sn_di[u] = s_di[u]; sn_sel[u] = s_sel[u];
            sn_do[u] = m_do[u]; sn_sdo[u] = s_do[u];
        end
        model_check();
        observe();
        cyc++;
        @(posedge clk);
        #1;
        apply();
    endtask

    task automatic request(int u, int p, logic [AW-1:0] a, bit we, logic [DW-1:0] base);
        req[u][p] = 1'b1; radr[u][p] = a; rwe[u][p] = we; dbase[u][p] = base; cont[u][p] = 1'b0;
        apply();
    endtask

    task automatic wait_eack(int u, output int port);
        port = -1;
        for (int n = 0; n < 60 && port < 0; n++) begin
            cycle();
            if (sn_eack[u] != '0) port = eack_port(sn_eack[u]);
        end
        if (port < 0) timeout_fail("wait_eack");
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        agents_clear();
        apply();
        repeat (2) cycle();
        rst_n = 1'b1;
        cycle();
    endtask

    initial begin
        int e, s, p;
        int exp_rr[6] = '{0, 1, 2, 3, 0, 1};
        int exp_fp[3] = '{1, 0, 3};
        for (int u = 0; u < 2; u++) begin
            ack_dly[u] = 1; own[u] = -1; lastp[u] = NP - 1; wr_e[u] = -1000; wr_p[u] = 0;
        end
        agents_clear();
        apply();
        repeat (3) cycle();
        rst_n = 1'b1;
        cycle();

        // single read on port 2, slave eack 3 cycles after s_stb
        ack_dly[0] = 3;
        request(0, 2, 26'h0001000, 1'b0, '0);
        s = -1; e = -1;
        for (int n = 0; n < 40 && e < 0; n++) begin
            cycle();
            if (s < 0 && sn_stb[0]) begin
                s = cyc - 1;
                chk("rd_s_adr", 64'(sn_adr[0]), 64'h0001000);
            end
            if (sn_eack[0] != '0) e = cyc - 1;
        end
        if (e < 0) timeout_fail("rd_eack");
        chk("rd_m_eack", 64'(sn_eack[0]), 64'b0100);
        chk("rd_eack_latency", 64'(e - s), 64'd3);
        chk("rd_m_do", 64'(sn_do[0]), 64'(sn_sdo[0]));
        cycle();
        chk("rd_eack_one_cycle", 64'(sn_eack[0]), 64'd0);
        chk("rd_busy_fall", 64'(sn_busy[0]), 64'd0);

        // single write on port 1, beats A0..A3
        ack_dly[0] = 1;
        request(0, 1, 26'h0002040, 1'b1, 32'hA0);
        wait_eack(0, p);
        chk("wr_eack_port", 64'(p), 64'd1);
        for (int k = 0; k < BL; k++) begin
            cycle();
            chk("wr_s_di", 64'(sn_di[0]), 64'(32'hA0 + k));
            chk("wr_s_sel", 64'(sn_sel[0]), 64'hF);
        end
        cycle();
        chk("wr_s_di_end", 64'(sn_di[0]), 64'd0);
        chk("wr_s_sel_end", 64'(sn_sel[0]), 64'd0);
        chk("wr_busy_end", 64'(sn_busy[0]), 64'd0);

        // round-robin with all ports requesting continuously
        do_reset();
        for (int q = 0; q < NP; q++) begin
            radr[0][q] = AW'(26'h3000 + q * 16); rwe[0][q] = 1'b0; cont[0][q] = 1'b1; req[0][q] = 1'b1;
        end
        apply();
        ngot = 0;
        for (int n = 0; n < 100 && ngot < 6; n++) begin
            cycle();
            if (sn_eack[0] != '0) begin
                got[ngot] = eack_port(sn_eack[0]);
                ngot++;
            end
        end
        if (ngot < 6) timeout_fail("rr_order");
        for (int k = 0; k < 6; k++) chk("rr_order", 64'(got[k]), 64'(exp_rr[k]));
        for (int q = 0; q < NP; q++) cont[0][q] = 1'b0;
        repeat (30) cycle();

        // fixed priority: ports 1 and 3 together, port 0 after first eack
        request(1, 1, 26'h0004100, 1'b0, '0);
        request(1, 3, 26'h0004300, 1'b0, '0);
        wait_eack(1, got[0]);
        request(1, 0, 26'h0004000, 1'b0, '0);
        wait_eack(1, got[1]);
        wait_eack(1, got[2]);
        for (int k = 0; k < 3; k++) chk("fp_order", 64'(got[k]), 64'(exp_fp[k]));
        repeat (4) cycle();

        // write overlap: port 0 write, port 3 read raised right after eack
        request(0, 0, 26'h0000100, 1'b1, 32'hB0);
        wait_eack(0, p);
        chk("ov_wr_port", 64'(p), 64'd0);
        request(0, 3, 26'h0002AAA, 1'b0, '0);
        cycle();
        chk("ov_e1_s_stb", 64'(sn_stb[0]), 64'd0);
        chk("ov_e1_s_di", 64'(sn_di[0]), 64'hB0);
        cycle();
        chk("ov_e2_s_stb", 64'(sn_stb[0]), 64'd1);
        chk("ov_e2_s_adr", 64'(sn_adr[0]), 64'h0002AAA);
        chk("ov_e2_s_di", 64'(sn_di[0]), 64'hB1);
        cycle();
        chk("ov_e3_m_eack", 64'(sn_eack[0]), 64'b1000);
        chk("ov_e3_s_di", 64'(sn_di[0]), 64'hB2);
        cycle();
        chk("ov_e4_s_di", 64'(sn_di[0]), 64'hB3);
        chk("ov_e4_busy", 64'(sn_busy[0]), 64'd1);
        cycle();
        chk("ov_e5_s_di", 64'(sn_di[0]), 64'd0);
        repeat (3) cycle();

        // reset in the middle of a write burst
        request(0, 2, 26'h0000200, 1'b1, 32'hC0);
        wait_eack(0, p);
        cycle();
        rst_n = 1'b0;
        agents_clear();
        req[0][3] = 1'b1; radr[0][3] = 26'h0003333; rwe[0][3] = 1'b0;
        apply();
        cycle();
        chk("rst_mid_s_stb", 64'(sn_stb[0]), 64'd0);
        chk("rst_mid_s_di", 64'(sn_di[0]), 64'd0);
        chk("rst_mid_s_sel", 64'(sn_sel[0]), 64'd0);
        chk("rst_mid_m_eack", 64'(sn_eack[0]), 64'd0);
        chk("rst_mid_busy", 64'(sn_busy[0]), 64'd0);
        rst_n = 1'b1;
        request(0, 0, 26'h0000300, 1'b0, '0);
        wait_eack(0, p);
        chk("rst_next_port", 64'(p), 64'd0);
        repeat (10) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
